// File: rtl/multicycle_controller.sv
// Main control FSM for a multicycle RV32-subset datapath: sequences fetch, decode,
// memory, ALU and writeback steps and drives the datapath select/enable lines.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic       illegal_op
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, JAL, BEQ, LUI
  } state_t;

  state_t state, next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= next;
  end

  always_comb begin
    next       = state;
    mem_req    = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    illegal_op = 1'b0;
    case (state)
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) next = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: next = MEMADR;
          OP_R:         next = EXECR;
          OP_I:         next = EXECI;
          OP_JAL:       next = JAL;
          OP_BEQ:       next = BEQ;
          OP_LUI:       next = LUI;
          default: begin
            illegal_op = 1'b1;
            next       = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        next      = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) next = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        next       = FETCH;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) next = FETCH;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        next      = ALUWB;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        next      = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        next      = FETCH;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        next      = ALUWB;
      end
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = zero;
        next      = FETCH;
      end
      LUI: begin
        result_src = 2'b11;
        reg_write  = 1'b1;
        next       = FETCH;
      end
      default: next = FETCH;
    endcase
    // Reset must silence enables combinationally, since FETCH itself requests memory.
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
    end
  end

  always_comb begin
    imm_src = 3'b000;
    case (op)
      OP_SW:  imm_src = 3'b001;
      OP_BEQ: imm_src = 3'b010;
      OP_JAL: imm_src = 3'b011;
      OP_LUI: imm_src = 3'b100;
      OP_R:   imm_src = 3'b111;
      default: imm_src = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction scenarios plus random
// instruction streams, checked cycle by cycle against a phase-queue model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, adr_src, mem_write, ir_write, pc_write, reg_write, illegal_op;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0] imm_src;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .imm_src(imm_src), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] LU  = 7'b0110111;

  typedef enum int {
    P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
    P_EXECR, P_EXECI, P_ALUWB, P_JAL, P_BEQ, P_LUI
  } ph_t;

  ph_t q[$];
  int  errors = 0;
  int  checks = 0;
  int  wcnt = 0;
  int  n_cyc, n_mw, n_rw, n_pc, n_ill;

  logic [17:0] dut_ctrl;
  logic [5:0]  dut_en;
  assign dut_ctrl = {mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
                     alu_src_a, alu_src_b, alu_op, result_src, imm_src, illegal_op};
  assign dut_en   = {mem_req, mem_write, ir_write, pc_write, reg_write, illegal_op};

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      SW: return 3'b001;
      BQ: return 3'b010;
      JL: return 3'b011;
      LU: return 3'b100;
      RT: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit supported(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == IT) ||
           (o == JL) || (o == BQ) || (o == LU);
  endfunction

  // Expected outputs for one cycle, straight from the per-step control table.
  function automatic logic [17:0] expect_ctrl(input ph_t p, input logic [6:0] o,
                                              input logic rdy, input logic z);
    logic mr, as, mw, iw, pw, rw, il;
    logic [1:0] a, b, ao, rs;
    {mr, as, mw, iw, pw, rw, il} = '0;
    {a, b, ao, rs} = '0;
    case (p)
      P_FETCH:    begin mr = 1; b = 2'b10; rs = 2'b10; iw = rdy; pw = rdy; end
      P_DECODE:   begin a = 2'b01; b = 2'b01; il = !supported(o); end
      P_MEMADR:   begin a = 2'b10; b = 2'b01; end
      P_MEMREAD:  begin mr = 1; as = 1; end
      P_MEMWB:    begin rs = 2'b01; rw = 1; end
      P_MEMWRITE: begin mr = 1; as = 1; mw = 1; end
      P_EXECR:    begin a = 2'b10; ao = 2'b10; end
      P_EXECI:    begin a = 2'b10; b = 2'b01; ao = 2'b10; end
      P_ALUWB:    begin rw = 1; end
      P_JAL:      begin a = 2'b01; b = 2'b10; pw = 1; end
      P_BEQ:      begin a = 2'b10; ao = 2'b01; pw = z; end
      P_LUI:      begin rs = 2'b11; rw = 1; end
      default:    ;
    endcase
    return {mr, as, mw, iw, pw, rw, a, b, ao, rs, imm_of(o), il};
  endfunction

  task automatic load_instr(input logic [6:0] o);
    q.delete();
    q.push_back(P_FETCH);
    q.push_back(P_DECODE);
    case (o)
      LW: begin q.push_back(P_MEMADR); q.push_back(P_MEMREAD); q.push_back(P_MEMWB); end
      SW: begin q.push_back(P_MEMADR); q.push_back(P_MEMWRITE); end
      RT: begin q.push_back(P_EXECR); q.push_back(P_ALUWB); end
      IT: begin q.push_back(P_EXECI); q.push_back(P_ALUWB); end
      JL: begin q.push_back(P_JAL); q.push_back(P_ALUWB); end
      BQ: q.push_back(P_BEQ);
      LU: q.push_back(P_LUI);
      default: ;
    endcase
    wcnt = 0;
  endtask

  task automatic check_vec(input string tag, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock cycle: starts 1 time unit after a rising edge, checks at the falling edge.
  task automatic cycle(input logic [6:0] iop, input int fwait, input int mwait, input logic z);
    ph_t  p;
    logic rdy;
    int   w;
    bit   waiting;
    p = q[0];
    waiting = (p == P_FETCH) || (p == P_MEMREAD) || (p == P_MEMWRITE);
    w = (p == P_FETCH) ? fwait : mwait;
    if (waiting) rdy = (w < 0) ? ($urandom_range(0, 2) != 0) : (wcnt >= w);
    else         rdy = 1'($urandom_range(0, 1));
    op        = (p == P_DECODE || p == P_MEMADR) ? iop : 7'($urandom);
    mem_ready = rdy;
    zero      = z;
    @(negedge clk);
    check_vec($sformatf("ctrl_%s", p.name()), dut_ctrl, expect_ctrl(p, op, rdy, z));
    n_cyc++;
    n_mw  += int'(mem_write);
    n_rw  += int'(reg_write);
    n_ill += int'(illegal_op);
    if (p != P_FETCH) n_pc += int'(pc_write);
    @(posedge clk);
    #1;
    if (waiting && !rdy) wcnt++;
    else begin
      void'(q.pop_front());
      wcnt = 0;
    end
  endtask

  task automatic run_instr(input logic [6:0] iop, input int fwait, input int mwait, input logic z);
    int guard;
    n_cyc = 0; n_mw = 0; n_rw = 0; n_pc = 0; n_ill = 0;
    load_instr(iop);
    guard = 0;
    while (q.size() > 0 && guard < 200) begin
      cycle(iop, fwait, mwait, z);
      guard++;
    end
    check_int("instr_completes", q.size(), 0);
    q.delete();
  endtask

  logic [6:0] pool [11];

  initial begin
    pool = '{LW, SW, RT, IT, JL, BQ, LU, 7'b1111111, 7'b0000000, 7'b0010111, 7'b1100111};
    rst_n = 1'b0; mem_ready = 1'b1; op = LW; zero = 1'b0;
    #2;
    check_int("reset_enables", int'(dut_en), 0);
    mem_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_instr(LW, 0, 0, 1'b0);
    check_int("lw_latency", n_cyc, 5);
    check_int("lw_regwrites", n_rw, 1);

    run_instr(SW, 0, 0, 1'b0);
    check_int("sw_latency", n_cyc, 4);
    run_instr(SW, 0, 3, 1'b0);
    check_int("sw_wait_memwrite", n_mw, 4);
    check_int("sw_wait_latency", n_cyc, 7);

    run_instr(RT, 0, 0, 1'b1);
    check_int("r_latency", n_cyc, 4);
    run_instr(IT, 2, 0, 1'b0);
    check_int("i_latency_fetchwait", n_cyc, 6);
    run_instr(JL, 0, 0, 1'b0);
    check_int("jal_latency", n_cyc, 4);
    check_int("jal_pcwrite", n_pc, 1);
    check_int("jal_regwrite", n_rw, 1);
    run_instr(BQ, 0, 0, 1'b1);
    check_int("beq_taken_pcwrite", n_pc, 1);
    check_int("beq_latency", n_cyc, 3);
    run_instr(BQ, 0, 0, 1'b0);
    check_int("beq_not_taken_pcwrite", n_pc, 0);
    run_instr(LU, 0, 0, 1'b0);
    check_int("lui_latency", n_cyc, 3);

    run_instr(7'b1111111, 0, 0, 1'b0);
    check_int("illegal_pulses", n_ill, 1);
    check_int("illegal_latency", n_cyc, 2);
    check_int("illegal_no_writes", n_rw + n_mw + n_pc, 0);

    // Reset during a MEMREAD wait, then a clean fetch.
    n_cyc = 0; n_mw = 0; n_rw = 0; n_pc = 0; n_ill = 0;
    load_instr(LW);
    repeat (3) cycle(LW, 0, 0, 1'b0);
    op = 7'($urandom); mem_ready = 1'b0;
    #2;
    check_int("memread_wait_req", int'(mem_req), 1);
    rst_n = 1'b0;
    #1;
    check_int("async_reset_enables", int'(dut_en), 0);
    @(posedge clk); #1;
    check_int("held_reset_enables", int'(dut_en), 0);
    mem_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #1;
    check_int("post_reset_fetch_req", int'(mem_req), 1);
    q.delete();
    @(posedge clk); #1;
    run_instr(IT, 0, 0, 1'b0);
    check_int("post_reset_instr", n_cyc, 4);

    for (int i = 0; i < 300; i++) begin
      logic [6:0] rop;
      rop = pool[$urandom_range(0, 10)];
      run_instr(rop, -1, -1, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
